mem_lsu: RTL and testbench

//   MEM pipeline stage with a load/store unit. Sits between EX/MEM and MEM/WB.
//   Non-memory ops pass their write-back fields through a registered output.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_lsu_if.sv | 15 +
 rtl/mem_lane_fmt.sv | 35 +++
 rtl/mem_lsu.sv | 123 ++++++++++++
 tb/tb_mem_lsu.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-op codes, exception codes, FSM states and byte-enable patterns
package mem_pkg;
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [3:0] BE_B   = 4'b0001;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    typedef enum logic [1:0] {EXC_NONE = 2'b00, EXC_MISAL = 2'b01, EXC_TMO = 2'b10} excp_e;
    typedef enum logic {S_IDLE, S_BUS} state_e;

    // Codes 9-15 are deliberately treated as non-memory ops.
    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data-bus between the load/store unit (master) and memory (slave)
interface mem_lsu_if #(parameter int ADDR_W = 32) ();
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                    input  mem_ack_i, mem_rdata_i);
    modport slave  (input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                    output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: store byte-enable/data packing, load lane extract and extend, alignment check
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [3:0]  memop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misal_o,
    output logic        store_o
);
    logic        half, word;
    logic [31:0] rsh;
    logic [15:0] hw;

    always_comb begin
        half    = (memop_i == OP_LH) || (memop_i == OP_LHU) || (memop_i == OP_SH);
        word    = (memop_i == OP_LW) || (memop_i == OP_SW);
        misal_o = (half && addr_i[0]) || (word && (addr_i != 2'b00));
        store_o = (memop_i == OP_SB) || (memop_i == OP_SH) || (memop_i == OP_SW);
        be_o    = (memop_i == OP_SB) ? 4'(BE_B << addr_i) :
                  (memop_i == OP_SH) ? (addr_i[1] ? BE_HHI : BE_HLO) : BE_W;
        wdata_o = (memop_i == OP_SB) ? {4{sdata_i[7:0]}} :
                  (memop_i == OP_SH) ? {2{sdata_i[15:0]}} : sdata_i;
        rsh     = rdata_i >> {addr_i, 3'b000};
        hw      = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ldata_o = (memop_i == OP_LB)  ? {{24{rsh[7]}}, rsh[7:0]} :
                  (memop_i == OP_LBU) ? {24'b0, rsh[7:0]} :
                  (memop_i == OP_LH)  ? {{16{hw[15]}}, hw} :
                  (memop_i == OP_LHU) ? {16'b0, hw} : rdata_i;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage with load/store unit; runs bus transactions and stalls upstream meanwhile
module mem_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        memop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [31:0]       wdata_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    output logic              stall_req_o,
    mem_lsu_if.master         bus,
    output logic              valid_o,
    output logic [31:0]       wdata_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [1:0]        excp_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              valid_q, wreg_q, req_q, we_q;
    logic [31:0]       wdata_q, bwdata_q;
    logic [REG_AW-1:0] wd_q;
    logic [1:0]        excp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q, be;
    logic [31:0]       sdata, ldata;
    logic              misal, store, tmo;

    mem_lane_fmt u_fmt (
        .memop_i(memop_i),
        .addr_i (mem_addr_i[1:0]),
        .sdata_i(mem_wdata_i),
        .rdata_i(bus.mem_rdata_i),
        .be_o   (be),
        .wdata_o(sdata),
        .ldata_o(ldata),
        .misal_o(misal),
        .store_o(store)
    );

    assign tmo         = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign stall_req_o = (state_q == S_IDLE) ? (valid_i && is_mem(memop_i) && !misal)
                                             : !bus.mem_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            wdata_q  <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            excp_q   <= EXC_NONE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            bwdata_q <= '0;
        end else begin
            excp_q <= EXC_NONE;
            if (state_q == S_IDLE) begin
                cnt_q   <= '0;
                valid_q <= valid_i && (!is_mem(memop_i) || misal);
                if (valid_i && !is_mem(memop_i)) begin
                    wdata_q <= wdata_i;
                    wd_q    <= wd_i;
                    wreg_q  <= wreg_i;
                end else if (valid_i && misal) begin
                    wd_q   <= wd_i;
                    wreg_q <= 1'b0;
                    excp_q <= EXC_MISAL;
                end else if (valid_i) begin
                    state_q  <= S_BUS;
                    req_q    <= 1'b1;
                    we_q     <= store;
                    addr_q   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                    be_q     <= be;
                    bwdata_q <= sdata;
                end
            end else if (bus.mem_ack_i) begin
                state_q <= S_IDLE;
                req_q   <= 1'b0;
                cnt_q   <= '0;
                valid_q <= 1'b1;
                wd_q    <= wd_i;
                wreg_q  <= store ? 1'b0 : wreg_i;
                if (!store) wdata_q <= ldata;
            end else if (tmo) begin
                state_q <= S_IDLE;
                req_q   <= 1'b0;
                cnt_q   <= '0;
                valid_q <= 1'b1;
                wd_q    <= wd_i;
                wreg_q  <= 1'b0;
                excp_q  <= EXC_TMO;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o         = valid_q;
    assign wdata_o         = wdata_q;
    assign wd_o            = wd_q;
    assign wreg_o          = wreg_q;
    assign excp_o          = excp_q;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_be_o    = be_q;
    assign bus.mem_wdata_o = bwdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors with hand-computed expectations for mem_lsu (TIMEOUT=4)
module tb_mem_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, wreg_i;
    logic [3:0]  memop_i;
    logic [31:0] mem_addr_i, mem_wdata_i, wdata_i;
    logic [4:0]  wd_i;
    logic        stall_req_o, valid_o, wreg_o;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic [1:0]  excp_o;
    int          n_chk = 0;
    int          n_err = 0;

    mem_lsu_if #(.ADDR_W(32)) bus ();

    mem_lsu #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .memop_i    (memop_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .wdata_i    (wdata_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .stall_req_o(stall_req_o),
        .bus        (bus),
        .valid_o    (valid_o),
        .wdata_o    (wdata_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .excp_o     (excp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] src);
        valid_i     = 1'b1;
        memop_i     = op;
        mem_addr_i  = addr;
        mem_wdata_i = src;
        wdata_i     = 32'h5555_5555;
        wd_i        = 5'd7;
        wreg_i      = 1'b1;
        #1;
    endtask

    // Called with the op already driven in IDLE; acks after `waits` BUS wait cycles.
    task automatic txn(input int waits, input logic [31:0] rd);
        chk("stall_idle", stall_req_o, 1);
        tick();
        chk("req_up", bus.mem_req_o, 1);
        for (int i = 0; i < waits; i++) begin
            chk("stall_wait", stall_req_o, 1);
            tick();
        end
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rd;
        #1;
        chk("stall_ack", stall_req_o, 0);
        tick();
        bus.mem_ack_i = 1'b0;
        chk("req_down", bus.mem_req_o, 0);
        chk("valid_done", valid_o, 1);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; memop_i = OP_NONE; mem_addr_i = '0; mem_wdata_i = '0;
        wdata_i = '0; wd_i = '0; wreg_i = 1'b0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        tick(); tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_req", bus.mem_req_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_excp", excp_o, 0);
        chk("rst_stall", stall_req_o, 0);
        rst = 1'b0;

        // NONE passes through in one cycle
        valid_i = 1'b1; memop_i = OP_NONE; wdata_i = 32'hDEAD_BEEF; wd_i = 5'd3; wreg_i = 1'b1;
        #1;
        chk("none_stall0", stall_req_o, 0);
        tick();
        chk("none_valid", valid_o, 1);
        chk("none_wdata", wdata_o, 32'hDEAD_BEEF);
        chk("none_wd", wd_o, 3);
        chk("none_wreg", wreg_o, 1);
        chk("none_stall1", stall_req_o, 0);
        valid_i = 1'b0;
        tick();
        chk("idle_valid", valid_o, 0);
        chk("idle_hold", wdata_o, 32'hDEAD_BEEF);

        // LB / LBU on lane 3 with two wait cycles
        drive(OP_LB, 32'h0000_0103, 0);
        txn(2, 32'h80FF_FF7F);
        chk("lb_data", wdata_o, 32'hFFFF_FF80);
        chk("lb_wreg", wreg_o, 1);
        chk("lb_addr", bus.mem_addr_o, 32'h0000_0100);
        chk("lb_we", bus.mem_we_o, 0);
        drive(OP_LBU, 32'h0000_0103, 0);
        txn(2, 32'h80FF_FF7F);
        chk("lbu_data", wdata_o, 32'h0000_0080);
        drive(OP_LH, 32'h0000_0102, 0);
        txn(0, 32'h8001_1234);
        chk("lh_data", wdata_o, 32'hFFFF_8001);
        drive(OP_LHU, 32'h0000_0100, 0);
        txn(1, 32'h8001_F234);
        chk("lhu_data", wdata_o, 32'h0000_F234);

        // Stores
        drive(OP_SH, 32'h0000_0202, 32'h1234_ABCD);
        txn(0, 0);
        chk("sh_be", bus.mem_be_o, 4'b1100);
        chk("sh_wdata", bus.mem_wdata_o, 32'hABCD_ABCD);
        chk("sh_we", bus.mem_we_o, 1);
        chk("sh_wreg", wreg_o, 0);
        drive(OP_SB, 32'h0000_0501, 32'h0000_00A5);
        txn(1, 0);
        chk("sb_be", bus.mem_be_o, 4'b0010);
        chk("sb_wdata", bus.mem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_addr", bus.mem_addr_o, 32'h0000_0500);

        // Misaligned LW
        drive(OP_LW, 32'h0000_0106, 0);
        chk("mis_stall", stall_req_o, 0);
        tick();
        chk("mis_req", bus.mem_req_o, 0);
        chk("mis_valid", valid_o, 1);
        chk("mis_excp", excp_o, 2'b01);
        chk("mis_wreg", wreg_o, 0);
        valid_i = 1'b0;
        tick();
        chk("mis_excp_clr", excp_o, 0);

        // Timeout: four BUS cycles without ack
        drive(OP_LW, 32'h0000_0300, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo_req", bus.mem_req_o, 1);
            chk("tmo_stall", stall_req_o, 1);
            chk("tmo_valid0", valid_o, 0);
        end
        valid_i = 1'b0;
        tick();
        chk("tmo_req_drop", bus.mem_req_o, 0);
        chk("tmo_valid", valid_o, 1);
        chk("tmo_excp", excp_o, 2'b10);
        chk("tmo_wreg", wreg_o, 0);
        tick();
        chk("tmo_once", excp_o, 0);
        chk("tmo_valid1", valid_o, 0);

        // Reset during BUS, then a stray ack
        drive(OP_LW, 32'h0000_0400, 0);
        tick();
        chk("rb_req", bus.mem_req_o, 1);
        rst = 1'b1;
        tick();
        chk("rb_req0", bus.mem_req_o, 0);
        chk("rb_valid", valid_o, 0);
        chk("rb_wdata", wdata_o, 0);
        chk("rb_wd", wd_o, 0);
        chk("rb_addr", bus.mem_addr_o, 0);
        chk("rb_be", bus.mem_be_o, 0);
        rst = 1'b0; valid_i = 1'b0;
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        chk("late_stall", stall_req_o, 0);
        tick();
        bus.mem_ack_i = 1'b0;
        chk("late_valid", valid_o, 0);
        chk("late_req", bus.mem_req_o, 0);
        chk("late_wdata", wdata_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
